// File: rtl/mips_cpu_mem_arbiter.sv
// Shares the CPU's single Avalon-MM master bus between instruction fetch and load/store.
// Define MIPS_CPU_MEM_ARB_RR_EN for round-robin grants; otherwise data has fixed priority over fetch.
module mips_cpu_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_address,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] memwritedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] memreaddata,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] memwritedata_q, memwritedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        owner_q, owner_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        grant_data;
`ifdef MIPS_CPU_MEM_ARB_RR_EN
  logic        last_data_q, last_data_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mem_address_q  <= '0;
      memwritedata_q <= '0;
      byteenable_q   <= '0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      owner_q        <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      if_done_q      <= 1'b0;
      d_done_q       <= 1'b0;
`ifdef MIPS_CPU_MEM_ARB_RR_EN
      last_data_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mem_address_q  <= mem_address_d;
      memwritedata_q <= memwritedata_d;
      byteenable_q   <= byteenable_d;
      memread_q      <= memread_d;
      memwrite_q     <= memwrite_d;
      owner_q        <= owner_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
      if_done_q      <= if_done_d;
      d_done_q       <= d_done_d;
`ifdef MIPS_CPU_MEM_ARB_RR_EN
      last_data_q    <= last_data_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_address_d  = mem_address_q;
    memwritedata_d = memwritedata_q;
    byteenable_d   = byteenable_q;
    memread_d      = memread_q;
    memwrite_d     = memwrite_q;
    owner_d        = owner_q;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    if_done_d      = 1'b0;
    d_done_d       = 1'b0;
`ifdef MIPS_CPU_MEM_ARB_RR_EN
    last_data_d    = last_data_q;
    // On a tie, serve whichever side did not win the previous grant.
    grant_data     = d_req && (!if_req || !last_data_q);
`else
    grant_data     = d_req;
`endif

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_BUS;
          owner_d = grant_data;
`ifdef MIPS_CPU_MEM_ARB_RR_EN
          last_data_d = grant_data;
`endif
          if (grant_data) begin
            mem_address_d  = d_addr;
            memwritedata_d = d_wdata;
            byteenable_d   = d_byteenable;
            memread_d      = !d_write;
            memwrite_d     = d_write;
          end else begin
            mem_address_d  = if_addr;
            byteenable_d   = 4'hF;
            memread_d      = 1'b1;
            memwrite_d     = 1'b0;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          memread_d  = 1'b0;
          memwrite_d = 1'b0;
          if (memread_q) begin
            if (owner_q) d_rdata_d  = memreaddata;
            else         if_rdata_d = memreaddata;
          end
          if (owner_q) d_done_d  = 1'b1;
          else         if_done_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address  = mem_address_q;
  assign memwritedata = memwritedata_q;
  assign byteenable   = byteenable_q;
  assign memread      = memread_q;
  assign memwrite     = memwrite_q;
  assign owner        = owner_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_done      = if_done_q;
  assign d_done       = d_done_q;

endmodule
